// File: rtl/la_glitchfilter_pkg.sv
// Shared types and constants for the la_glitchfilter glitch filter.
package la_glitchfilter_pkg;

  // Filter FSM: STABLE when z matches the sampled level, CHECK while a change qualifies.
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_e;

  // Largest supported stability requirement in cycles.
  localparam int unsigned N_MAX = 255;

  // Width of a counter that must hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-stage synchronizer cell. Both stages reset to RSTVAL so that leaving
// reset does not present a false edge downstream.
module la_dsync #(
  parameter logic RSTVAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RSTVAL;
      sync_q <= RSTVAL;
    end else begin
      meta_q <= in;
      sync_q <= meta_q;
    end
  end

  assign out = sync_q;

endmodule

// File: rtl/la_glitchfilter.sv
// Registered glitch filter and edge detector for one combinational level.
// A new sampled level reaches z only after holding for N consecutive enabled
// cycles; rise/fall pulse for one cycle on each accepted transition.
// Build option: define LA_GLITCHFILTER_SYNC_EN to sample `in` through a
// 2-flop synchronizer (la_dsync) instead of a single flop (one extra cycle of latency).
module la_glitchfilter
  import la_glitchfilter_pkg::*;
#(
  parameter string       PROP   = "DEFAULT",
  parameter int unsigned N      = 4,
  parameter logic        RSTVAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic en,
  output logic z,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned   CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // PROP only steers technology mapping; an empty tag is treated as a setup mistake.
  if (N == 0 || N > N_MAX) begin : g_bad_n
    $error("la_glitchfilter: N=%0d is outside 1..%0d", N, N_MAX);
  end
  if (PROP == "") begin : g_bad_prop
    $error("la_glitchfilter: PROP must not be empty");
  end

  logic samp;

`ifdef LA_GLITCHFILTER_SYNC_EN
  la_dsync #(
    .RSTVAL(RSTVAL)
  ) u_dsync (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (samp)
  );
`else
  logic samp_q;

  // Single sampling flop; only safe for sources already in this clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= RSTVAL;
    end else begin
      samp_q <= in;
    end
  end

  assign samp = samp_q;
`endif

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          z_q;
  logic          rise_q;
  logic          fall_q;

  // Qualification FSM with counter, filtered level and edge pulses all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      z_q     <= RSTVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!en) begin
        // Disabling aborts any qualification in progress; z holds its level.
        state_q <= STABLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          STABLE: begin
            if (samp != z_q) begin
              if (N == 1) begin
                z_q    <= samp;
                rise_q <= samp;
                fall_q <= ~samp;
              end else begin
                state_q <= CHECK;
                cnt_q   <= CW'(1);
              end
            end
          end
          CHECK: begin
            if (samp == z_q) begin
              // Level went back before qualifying: drop it and start over next time.
              state_q <= STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              z_q     <= samp;
              rise_q  <= samp;
              fall_q  <= ~samp;
              state_q <= STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign z    = z_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == CHECK);

endmodule

// File: tb/tb_la_glitchfilter.sv
// Self-checking bench for la_glitchfilter: one N=4 instance and one N=1 instance
// share the clock. A run-length reference model checks both every cycle, a
// vector table checks the basic N=4 waveforms, and hand-written sequences cover
// enable abort, reset during qualification and N=1 toggling.
module tb_la_glitchfilter;

`ifdef LA_GLITCHFILTER_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in4, en4, in1, en1;
  logic z4, rise4, fall4, busy4;
  logic z1, rise1, fall1, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  la_glitchfilter #(
    .PROP  ("DEFAULT"),
    .N     (4),
    .RSTVAL(1'b0)
  ) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .in   (in4),
    .en   (en4),
    .z    (z4),
    .rise (rise4),
    .fall (fall4),
    .busy (busy4)
  );

  la_glitchfilter #(
    .PROP  ("DEFAULT"),
    .N     (1),
    .RSTVAL(1'b0)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .in   (in1),
    .en   (en1),
    .z    (z1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  // Reference model: z flips once the sampled level has disagreed with z on
  // N consecutive enabled edges. Index 0 models N=4, index 1 models N=1.
  int unsigned nval[2] = '{4, 1};
  logic mz[2], mr[2], mf[2], mb[2];
  logic pipe0[2], pipe1[2];
  int   run[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mz[d] = 1'b0; mr[d] = 1'b0; mf[d] = 1'b0; mb[d] = 1'b0;
      pipe0[d] = 1'b0; pipe1[d] = 1'b0; run[d] = 0;
    end
  endtask

  task automatic model_step();
    logic i_d, e_d, s;
    for (int d = 0; d < 2; d++) begin
      i_d = (d == 0) ? in4 : in1;
      e_d = (d == 0) ? en4 : en1;
      s = (SYNC != 0) ? pipe1[d] : pipe0[d];
      pipe1[d] = pipe0[d];
      pipe0[d] = i_d;
      mr[d] = 1'b0;
      mf[d] = 1'b0;
      if (!e_d) begin
        run[d] = 0;
      end else if (s != mz[d]) begin
        run[d]++;
        if (run[d] == int'(nval[d])) begin
          mz[d] = ~mz[d];
          mr[d] = mz[d];
          mf[d] = ~mz[d];
          run[d] = 0;
        end
      end else begin
        run[d] = 0;
      end
      mb[d] = (run[d] != 0);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check1("model_z4", z4, mz[0]);
    check1("model_rise4", rise4, mr[0]);
    check1("model_fall4", fall4, mf[0]);
    check1("model_busy4", busy4, mb[0]);
    check1("model_z1", z1, mz[1]);
    check1("model_rise1", rise1, mr[1]);
    check1("model_fall1", fall1, mf[1]);
    check1("model_busy1", busy1, mb[1]);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct packed {
    logic in_v;
    logic z_v;
    logic rise_v;
    logic fall_v;
    logic busy_v;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int   k;
    vec_t ex;
    logic zprev;

    // Expected N=4 outputs after each edge, unsynchronized timing; the
    // synchronized build sees the same waveform one edge later.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset and idle.
    reset = 1'b1;
    in4 = 1'b0; en4 = 1'b1; in1 = 1'b0; en1 = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check1("reset_z4", z4, 1'b0);
    check1("reset_busy4", busy4, 1'b0);
    check1("reset_rise4", rise4, 1'b0);
    check1("reset_fall4", fall4, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check1("idle_z4", z4, 1'b0);
      check1("idle_pulse4", rise4 | fall4 | busy4, 1'b0);
    end

    // Vector table on the N=4 instance.
    for (int i = 0; i < 24; i++) begin
      in4 = tbl[i].in_v;
      cycle();
      ex = (i < SYNC) ? vec_t'(0) : tbl[i - SYNC];
      check1("tbl_z4", z4, ex.z_v);
      check1("tbl_rise4", rise4, ex.rise_v);
      check1("tbl_fall4", fall4, ex.fall_v);
      check1("tbl_busy4", busy4, ex.busy_v);
    end

    // Enable dropped for one cycle at cnt=2 restarts the count.
    in4 = 1'b1;
    repeat (8) cycle();
    check1("abort_setup_z4", z4, 1'b1);
    in4 = 1'b0;
    k = 0;
    while (!busy4 && k < 10) begin
      cycle();
      k++;
    end
    check1("abort_busy_seen", busy4, 1'b1);
    cycle();
    en4 = 1'b0;
    cycle();
    check1("abort_busy_cleared", busy4, 1'b0);
    check1("abort_z_held", z4, 1'b1);
    check1("abort_no_fall", fall4, 1'b0);
    en4 = 1'b1;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!fall4 && k < 20);
    check_int("abort_fall_latency", k, 4);
    check1("abort_z_after", z4, 1'b0);

    // Reset asserted mid-qualification.
    in4 = 1'b1;
    k = 0;
    while (!busy4 && k < 10) begin
      cycle();
      k++;
    end
    check1("midreset_busy_seen", busy4, 1'b1);
    cycle();
    reset = 1'b1;
    #1;
    check1("midreset_z4", z4, 1'b0);
    check1("midreset_busy4", busy4, 1'b0);
    check1("midreset_rise4", rise4, 1'b0);
    check1("midreset_fall4", fall4, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!rise4 && k < 20);
    check_int("midreset_restart_latency", k, 4 + 1 + SYNC);

    // N=1: held change latency, then toggling every cycle.
    in1 = 1'b1;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!z1 && k < 10);
    check_int("n1_latency", k, 1 + 1 + SYNC);
    cycle();
    for (int i = 0; i < 12; i++) begin
      zprev = z1;
      in1 = ~in1;
      cycle();
      if (i >= 2) begin
        check1("n1_toggle_z", z1, ~zprev);
        check1("n1_toggle_pulse", rise1 ^ fall1, 1'b1);
        check1("n1_rise_matches_z", rise1, z1);
      end
    end

    // Random traffic against the model: slow-changing level on N=4, fast on N=1.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) in4 = ~in4;
      in1 = 1'($urandom_range(0, 1));
      en4 = ($urandom_range(0, 24) != 0);
      en1 = ($urandom_range(0, 24) != 0);
      cycle();
      check1("rand_excl4", rise4 & fall4, 1'b0);
      check1("rand_excl1", rise1 & fall1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/la_glitchfilter.md
# la_glitchfilter

Registered glitch filter and edge detector for a single combinational logic output, such as a NAND/AND/OR cell output used as a control or status condition. The raw level is sampled, optionally synchronized, and propagated to `z` only after it has held a new value for `N` consecutive clock cycles. One-cycle `rise`/`fall` pulses mark each accepted transition. The block sits directly downstream of stdlib combinational gates whose outputs must drive sequential control logic.

## Interface
Parameters:
- `PROP`, "DEFAULT", implementation property string passed through to technology mapping; no functional effect.
- `N`, 4, required stability in cycles; legal range 1..255. Out-of-range values are an elaboration error.
- `RSTVAL`, 1'b0, reset level of `z` and of all sampling flops.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  clock; all flops are rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in`  input  1  raw level, typically a gate output.
- `en`  input  1  filter enable.
- `z`  output  1  filtered level.
- `rise`  output  1  one-cycle pulse when `z` goes 0->1.
- `fall`  output  1  one-cycle pulse when `z` goes 1->0.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation
- Sampler: `samp` is `in` registered (1 flop), or the output of a 2-flop synchronizer when configured (see Configuration).
- Counter `cnt` width is CW = $clog2(N+1).
- States: STABLE, CHECK. `busy` = (state == CHECK).
- STABLE, `en`=1, `samp`!=`z`:
  - N==1: flip `z` and pulse `rise`/`fall`; stay in STABLE.
  - N>1: go to CHECK with `cnt`=1.
- CHECK, `samp`==`z`: glitch rejected. Go to STABLE with `cnt`=0; `z` unchanged; no pulse.
- CHECK, `samp`!=`z`, `cnt`<N-1: increment `cnt`.
- CHECK, `samp`!=`z`, `cnt`==N-1: on that edge, `z` <= ~`z`, assert `rise` (new `z`=1) or `fall` (new `z`=0) for exactly one cycle, go to STABLE with `cnt`=0.
- `en`=0: state forced to STABLE and `cnt`=0 (any qualification in progress is aborted). `z` holds. No pulses. Sampler keeps running.
- `rise` and `fall` are registered and mutually exclusive; never both high.
- Reset: `z`=RSTVAL, sampler flops=RSTVAL, state=STABLE, `cnt`=0, `rise`=`fall`=`busy`=0. Because sampler flops reset to RSTVAL, releasing reset produces no spurious event.
- Reset asserted mid-CHECK discards the count; no pulse is emitted.

## Timing
- Latency from an `in` change (stable before edge e0) to `z` change:
  - Unsynchronized: N+1 rising edges.
  - Synchronized: N+2 rising edges.
- `rise`/`fall` assert in the same cycle `z` changes and clear on the next edge.
- Minimum rejected glitch: any excursion of `samp` shorter than N cycles.
- A transition back to the old level during CHECK restarts qualification from zero.
- `en` takes effect on the first edge at which it is sampled.
- Outputs are glitch-free; all are flop outputs.

## Configuration
- Macro `LA_GLITCHFILTER_SYNC_EN`.
- Defined: `in` passes through a 2-flop synchronizer (`la_dsync`) before the filter. Use for asynchronous or other-domain sources. Latency N+2.
- Undefined: a single sampling flop. Use for same-clock sources only. Latency N+1.
- The rest of the behaviour is identical in both builds.

## Structure
- Package `la_glitchfilter_pkg`:
  - state typedef (1-bit enum STABLE/CHECK);
  - `N_MAX`=255 constant;
  - CW helper function.
- Sub-module `la_dsync` (existing 2-stage synchronizer cell), instantiated only under the macro.
- Everything else stays in one module: FSM, counter, output and pulse registers.

## Test plan
- Reset with RSTVAL=0, `in`=0, release reset, hold 20 cycles -> `z`=0, `rise`=`fall`=`busy`=0 throughout.
- N=4, no sync, `in` 0->1 held -> `busy` high for 3 cycles, `z`=1 and `rise`=1 exactly 5 edges after the change; `rise` low on the next cycle.
- N=4, `in` high for 3 cycles then low -> `busy` pulses; `z` stays 0; no `rise`.
- N=4, `z`=1, `in` 1->0 held, `en` dropped at `cnt`=2 for 1 cycle, then restored -> count restarts; `fall` asserts 4 cycles after `en` returns.
- N=1 with macro defined -> each held `in` change reaches `z` in 3 edges; alternating `in` every cycle toggles `z` every cycle with alternating `rise`/`fall`.
- Assert `reset` mid-CHECK -> immediately `z`=RSTVAL, `busy`=0, no pulse; after release, qualification restarts from zero.
